// File: rtl/sys_bus_interconnect_sync.sv
// sys_bus_interconnect_sync: registered one-master to SN-slave bus with broadcast ("sync") writes.
// Latency: master ack 3+ cycles after strobe; 2 on a decode error; TMO+2 on slave timeout.
// Backpressure: one transaction outstanding; master strobes outside IDLE are dropped and never acked.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   m_addr_i, m_wdata_i           master address / write data
//   m_wen_i, m_ren_i              master write / read strobes (write wins if both set)
//   m_rdata_o, m_err_o, m_ack_o   master response, ack is a one-cycle pulse
//   s_addr_o, s_wdata_o           address / write data shared by all slaves, held REQ..RESP
//   s_wen_o, s_ren_o              per-slave one-cycle strobes
//   s_rdata_i, s_err_i, s_ack_i   per-slave responses
module sys_bus_interconnect_sync #(
  parameter int              SN            = 16,
  parameter int              SW            = 20,
  parameter int              SYNC_IN_BUS   = -1,
  parameter logic [SN-1:0]   SYNC_OUT_MASK = '0,
  parameter int              NR            = 4,
  parameter int              SYNC_REG_OFS [NR] = '{default: -1},
  parameter int              TMO           = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          m_addr_i,
  input  logic [31:0]          m_wdata_i,
  input  logic                 m_wen_i,
  input  logic                 m_ren_i,
  output logic [31:0]          m_rdata_o,
  output logic                 m_err_o,
  output logic                 m_ack_o,
  output logic [31:0]          s_addr_o,
  output logic [31:0]          s_wdata_o,
  output logic [SN-1:0]        s_wen_o,
  output logic [SN-1:0]        s_ren_o,
  input  logic [SN-1:0][31:0]  s_rdata_i,
  input  logic [SN-1:0]        s_err_i,
  input  logic [SN-1:0]        s_ack_i
);

  localparam int            SL   = (SN > 1) ? $clog2(SN) : 1;
  localparam int            CW   = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [SL:0]   SN_L = (SL + 1)'(SN);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t         state_q;
  logic [31:0]    addr_q, wdata_q, rdata_q;
  logic           wr_q, derr_q, ack_q, err_q;
  logic [SN-1:0]  pend_q, wen_q, ren_q;
  logic [CW-1:0]  cnt_q;

  // Request decode, evaluated on the incoming master address.
  logic [SL-1:0]  idx_d;
  logic           dec_err_d, sync_hit_d;
  logic [SN-1:0]  sel_d, tgt_d;

  always_comb begin
    idx_d     = m_addr_i[SW +: SL];
    dec_err_d = ({1'b0, idx_d} >= SN_L);
    sel_d     = '0;
    for (int i = 0; i < SN; i++) begin
      if (idx_d == SL'(i)) sel_d[i] = 1'b1;
    end
    sync_hit_d = 1'b0;
    if (SYNC_IN_BUS >= 0 && SYNC_IN_BUS < SN && idx_d == SL'(SYNC_IN_BUS)) begin
      for (int k = 0; k < NR; k++) begin
        if (SYNC_REG_OFS[k] >= 0 && m_addr_i[SW-1:0] == SW'(SYNC_REG_OFS[k])) sync_hit_d = 1'b1;
      end
    end
    tgt_d = sel_d;
    if (m_wen_i && sync_hit_d) tgt_d = sel_d | SYNC_OUT_MASK;
    if (dec_err_d) tgt_d = '0;
  end

  // Response collection: only the first ack of each still-pending target counts.
  logic [SN-1:0]  hit_d, pend_d;
  logic           err_hit_d, rd_hit_d, tmo_hit_d;
  logic [31:0]    rd_dat_d;

  always_comb begin
    hit_d     = pend_q & s_ack_i;
    pend_d    = pend_q & ~s_ack_i;
    err_hit_d = |(hit_d & s_err_i);
    rd_hit_d  = 1'b0;
    rd_dat_d  = '0;
    // A read has a single target, so at most one hit bit is set here.
    for (int i = 0; i < SN; i++) begin
      if (hit_d[i]) begin
        rd_hit_d = !wr_q;
        rd_dat_d = s_rdata_i[i];
      end
    end
    // cnt_q holds the WAIT cycles already spent; this cycle is the TMO-th one.
    tmo_hit_d = (TMO != 0) && (cnt_q == CW'(TMO - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      derr_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= '0;
      wen_q   <= '0;
      ren_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // Slave strobes are single-cycle pulses by default.
      wen_q <= '0;
      ren_q <= '0;
      case (state_q)
        IDLE: begin
          if (m_wen_i || m_ren_i) begin
            addr_q  <= m_addr_i;
            wdata_q <= m_wdata_i;
            wr_q    <= m_wen_i;
            derr_q  <= dec_err_d;
            pend_q  <= tgt_d;
            cnt_q   <= '0;
            if (m_wen_i) wen_q <= tgt_d;
            else         ren_q <= tgt_d;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (derr_q) begin
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end else begin
            // Acks landing in the strobe cycle already retire their slave.
            pend_q  <= pend_d;
            err_q   <= err_q | err_hit_d;
            if (rd_hit_d) rdata_q <= rd_dat_d;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          pend_q <= pend_d;
          err_q  <= err_q | err_hit_d;
          if (rd_hit_d) rdata_q <= rd_dat_d;
          if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
          if (pend_d == '0) begin
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else if (tmo_hit_d) begin
            // Abandon stragglers: clearing pending makes their later acks irrelevant.
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
            pend_q  <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          pend_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if (SW + SL < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^m_addr_i[31:SW+SL];
  end

  assign m_rdata_o = rdata_q;
  assign m_err_o   = err_q;
  assign m_ack_o   = ack_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_wen_o   = wen_q;
  assign s_ren_o   = ren_q;

endmodule

// File: tb/tb_sys_bus_interconnect_sync.sv
`timescale 1ns/1ps
module tb_sys_bus_interconnect_sync;

  localparam int SN  = 5;
  localparam int SW  = 20;
  localparam int TMO = 8;
  localparam int SIB = 1;
  localparam int WIN = 16;
  localparam logic [SN-1:0] SOM = 5'b01100;
  localparam int OFS [4] = '{0, -1, -1, -1};

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic [31:0]          m_addr_i, m_wdata_i, m_rdata_o, s_addr_o, s_wdata_o;
  logic                 m_wen_i, m_ren_i, m_err_o, m_ack_o;
  logic [SN-1:0]        s_wen_o, s_ren_o, s_err_i, s_ack_i;
  logic [SN-1:0][31:0]  s_rdata_i;

  sys_bus_interconnect_sync #(
    .SN(SN), .SW(SW), .SYNC_IN_BUS(SIB), .SYNC_OUT_MASK(SOM), .NR(4),
    .SYNC_REG_OFS(OFS), .TMO(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wen_i(m_wen_i), .m_ren_i(m_ren_i),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .m_ack_o(m_ack_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wen_o(s_wen_o), .s_ren_o(s_ren_o),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .s_ack_i(s_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Slave behaviour: lat[i] = cycles from strobe to ack (0 = same cycle), -1 = never.
  int           lat  [SN];
  int           rem  [SN] = '{default: -1};
  logic [31:0]  rdat [SN];
  logic [SN-1:0] serr_v;
  logic [SN-1:0] ack_v;

  always @(negedge clk_i) begin
    for (int i = 0; i < SN; i++) begin
      if (rst_i) rem[i] = -1;
      else if (s_wen_o[i] || s_ren_o[i]) rem[i] = lat[i];
      ack_v[i] = (rem[i] == 0);
      if (rem[i] >= 0) rem[i] = rem[i] - 1;
      s_rdata_i[i] = rdat[i];
    end
    s_ack_i = ack_v;
    s_err_i = serr_v;
  end

  function automatic void set_defaults();
    for (int i = 0; i < SN; i++) begin
      lat[i]  = 1;
      rdat[i] = 32'h1000_0000 + 32'(i) * 32'h111;
    end
    rdat[2] = 32'h1234_5678;
    serr_v  = '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    int            nack;
    int            nstrb;
    logic          err;
    logic [31:0]   rd;
    logic [SN-1:0] w;
    logic [SN-1:0] r;
    logic          addr_ok;
  } res_t;

  // Issue one master strobe (cycle 0) and observe cycles 1..WIN.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic re, output res_t res);
    res = '{cyc: -1, nack: 0, nstrb: 0, err: 1'b0, rd: '0, w: '0, r: '0, addr_ok: 1'b1};
    @(negedge clk_i);
    m_addr_i = a; m_wdata_i = d; m_wen_i = we; m_ren_i = re;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk_i);
      m_wen_i = 1'b0; m_ren_i = 1'b0;
      if ((|s_wen_o) || (|s_ren_o)) begin
        res.nstrb++;
        res.w |= s_wen_o;
        res.r |= s_ren_o;
        if (s_addr_o !== a || (we && s_wdata_o !== d)) res.addr_ok = 1'b0;
      end
      if (m_ack_o) begin
        res.nack++;
        if (res.cyc < 0) begin
          res.cyc = k; res.err = m_err_o; res.rd = m_rdata_o;
        end
      end
    end
  endtask

  task automatic check_txn(input string nm, input res_t r, input int ecyc, input logic eerr,
                           input logic [31:0] erd, input logic [SN-1:0] ew, input logic [SN-1:0] er);
    chk({nm, " ack_cycle"}, r.cyc, ecyc);
    chk({nm, " ack_count"}, r.nack, 1);
    chk({nm, " err"}, 32'(r.err), 32'(eerr));
    chk({nm, " rdata"}, r.rd, erd);
    chk({nm, " wen_mask"}, 32'(r.w), 32'(ew));
    chk({nm, " ren_mask"}, 32'(r.r), 32'(er));
    chk({nm, " strobe_cycles"}, r.nstrb, ((ew | er) != '0) ? 1 : 0);
    chk({nm, " addr_wdata"}, 32'(r.addr_ok), 1);
  endtask

  // Reference: target set from the decode rules, timing from slave ack cycles.
  function automatic void model(input logic [31:0] a, input logic we, output logic [SN-1:0] tgt,
                                output int cyc, output logic err, output logic [31:0] rd);
    int idx, last;
    bit to, sync;
    idx = int'(a[22:20]);
    tgt = '0; err = 1'b0; rd = '0;
    if (idx >= SN) begin
      cyc = 2; err = 1'b1;
      return;
    end
    tgt[idx] = 1'b1;
    sync = 0;
    for (int k = 0; k < 4; k++) if (OFS[k] >= 0 && a[19:0] == 20'(OFS[k])) sync = 1;
    if (we && idx == SIB && sync) tgt |= SOM;
    last = 0; to = 0;
    for (int i = 0; i < SN; i++) begin
      if (tgt[i]) begin
        // Slave ack lands in cycle 1+lat; the last WAIT cycle is TMO+1.
        if (lat[i] < 0 || lat[i] > TMO) to = 1;
        else begin
          if (1 + lat[i] > last) last = 1 + lat[i];
          if (serr_v[i]) err = 1'b1;
        end
      end
    end
    if (to) begin
      cyc = TMO + 2; err = 1'b1; rd = '0;
    end else begin
      cyc = (last + 1 < 3) ? 3 : last + 1;
      if (!we) rd = rdat[idx];
    end
  endfunction

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          we;
    logic          re;
    int            slow_idx;
    int            slow_lat;
    int            err_idx;
    int            ecyc;
    logic          eerr;
    logic [31:0]   erd;
    logic [SN-1:0] ew;
    logic [SN-1:0] er;
  } vec_t;

  vec_t tbl [12];

  initial begin
    res_t          r;
    logic [SN-1:0] tgt;
    int            ecyc, nack, nstrb;
    logic          eerr, we, re;
    logic [31:0]   erd, a, off;

    m_addr_i = '0; m_wdata_i = '0; m_wen_i = 1'b0; m_ren_i = 1'b0;
    set_defaults();
    #1 rst_i = 1'b1;
    #3;
    chk("reset ack", 32'(m_ack_o), 0);
    chk("reset err", 32'(m_err_o), 0);
    chk("reset rdata", m_rdata_o, 0);
    chk("reset strobes", 32'({s_wen_o, s_ren_o}), 0);
    chk("reset addr", s_addr_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;

    tbl[0]  = '{32'h0020_0010, 32'h0,  1'b0, 1'b1, -1, 0, -1, 3,  1'b0, 32'h1234_5678, 5'b00000, 5'b00100};
    tbl[1]  = '{32'h0010_0000, 32'hA5, 1'b1, 1'b0,  3, 6, -1, 8,  1'b0, 32'h0,         5'b01110, 5'b00000};
    tbl[2]  = '{32'h0010_0004, 32'h5A, 1'b1, 1'b0,  3, 6, -1, 3,  1'b0, 32'h0,         5'b00010, 5'b00000};
    tbl[3]  = '{32'h0060_0000, 32'h0,  1'b0, 1'b1, -1, 0, -1, 2,  1'b1, 32'h0,         5'b00000, 5'b00000};
    tbl[4]  = '{32'h0070_0000, 32'h77, 1'b1, 1'b0, -1, 0, -1, 2,  1'b1, 32'h0,         5'b00000, 5'b00000};
    tbl[5]  = '{32'h0010_0000, 32'h0,  1'b0, 1'b1, -1, 0, -1, 3,  1'b0, 32'h1000_0111, 5'b00000, 5'b00010};
    tbl[6]  = '{32'h0000_0000, 32'h11, 1'b1, 1'b0, -1, 0, -1, 3,  1'b0, 32'h0,         5'b00001, 5'b00000};
    tbl[7]  = '{32'h0010_0000, 32'h22, 1'b1, 1'b0, -1, 0,  2, 3,  1'b1, 32'h0,         5'b01110, 5'b00000};
    tbl[8]  = '{32'h0040_0008, 32'h0,  1'b0, 1'b1,  4, 0, -1, 3,  1'b0, 32'h1000_0444, 5'b00000, 5'b10000};
    tbl[9]  = '{32'h0030_0000, 32'h0,  1'b0, 1'b1,  3, 8, -1, 10, 1'b0, 32'h1000_0333, 5'b00000, 5'b01000};
    tbl[10] = '{32'h0030_0000, 32'h0,  1'b0, 1'b1,  3, 9, -1, 10, 1'b1, 32'h0,         5'b00000, 5'b01000};
    tbl[11] = '{32'h0000_0040, 32'h33, 1'b1, 1'b1, -1, 0, -1, 3,  1'b0, 32'h0,         5'b00001, 5'b00000};

    for (int v = 0; v < 12; v++) begin
      set_defaults();
      if (tbl[v].slow_idx >= 0) lat[tbl[v].slow_idx] = tbl[v].slow_lat;
      if (tbl[v].err_idx >= 0) serr_v[tbl[v].err_idx] = 1'b1;
      run_txn(tbl[v].addr, tbl[v].wdata, tbl[v].we, tbl[v].re, r);
      check_txn($sformatf("vec%0d", v), r, tbl[v].ecyc, tbl[v].eerr, tbl[v].erd, tbl[v].ew, tbl[v].er);
    end

    // Slave 4 misses the timeout window; its late ack must not produce a second master ack.
    set_defaults();
    lat[4] = 12;
    run_txn(32'h0040_0000, 32'h0, 1'b0, 1'b1, r);
    check_txn("timeout_late_ack", r, TMO + 2, 1'b1, 32'h0, 5'b00000, 5'b10000);

    // Master strobe while busy is ignored: no extra slave strobe, single ack.
    set_defaults();
    lat[3] = 4;
    @(negedge clk_i);
    m_addr_i = 32'h0030_0000; m_ren_i = 1'b1;
    nack = 0; nstrb = 0; ecyc = -1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk_i);
      m_ren_i = 1'b0;
      m_wen_i = (k == 2);
      if (k == 2) m_addr_i = 32'h0000_0000;
      if ((|s_wen_o) || (|s_ren_o)) nstrb++;
      if (m_ack_o) begin
        nack++;
        if (ecyc < 0) ecyc = k;
      end
    end
    m_wen_i = 1'b0;
    chk("busy_strobe ack_count", nack, 1);
    chk("busy_strobe ack_cycle", ecyc, 6);
    chk("busy_strobe strobe_cycles", nstrb, 1);

    // Asynchronous reset mid-transaction.
    set_defaults();
    lat[3] = -1;
    @(negedge clk_i);
    m_addr_i = 32'h0030_0000; m_wdata_i = 32'hDEAD_BEEF; m_ren_i = 1'b1;
    @(negedge clk_i);
    m_ren_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_pre addr", s_addr_o, 32'h0030_0000);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async ack", 32'(m_ack_o), 0);
    chk("rst_async err", 32'(m_err_o), 0);
    chk("rst_async rdata", m_rdata_o, 0);
    chk("rst_async strobes", 32'({s_wen_o, s_ren_o}), 0);
    chk("rst_async addr", s_addr_o, 0);
    chk("rst_async wdata", s_wdata_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    nack = 0;
    repeat (WIN) begin
      @(negedge clk_i);
      if (m_ack_o) nack++;
    end
    chk("rst_dropped ack_count", nack, 0);
    run_txn(32'h0020_0010, 32'h0, 1'b0, 1'b1, r);
    check_txn("post_reset_read", r, 3, 1'b0, 32'h1234_5678, 5'b00000, 5'b00100);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       off = 32'h0;
        1:       off = 32'h4;
        default: off = 32'($urandom_range(0, 32'hF_FFFF)) & 32'hF_FFFC;
      endcase
      a = (32'($urandom_range(0, 7)) << 20) | off;
      case ($urandom_range(0, 2))
        0:       begin we = 1'b0; re = 1'b1; end
        1:       begin we = 1'b1; re = 1'b0; end
        default: begin we = 1'b1; re = 1'b1; end
      endcase
      for (int i = 0; i < SN; i++) begin
        case ($urandom_range(0, 9))
          0:       lat[i] = -1;
          1, 2:    lat[i] = int'($urandom_range(5, 12));
          default: lat[i] = int'($urandom_range(0, 3));
        endcase
        rdat[i]   = $urandom;
        serr_v[i] = ($urandom_range(0, 7) == 0);
      end
      model(a, we, tgt, ecyc, eerr, erd);
      run_txn(a, $urandom, we, re, r);
      check_txn($sformatf("rand%0d", n), r, ecyc, eerr, erd, we ? tgt : '0, we ? '0 : tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
